// File: rtl/learn_score_ctrl.sv
// Learn-mode session controller: requests notes, judges the player's keys over a
// fixed window per note, counts hits, grades the session and keeps per-user bests.
module learn_score_ctrl #(
    parameter int         NOTE_WIN   = 50_000_000,
    parameter int         HIT_MIN    = 25_000_000,
    parameter int         SONG_LEN   = 32,
    parameter logic [1:0] LEARN_CODE = 2'b10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic [1:0] WhichUser,
    input  logic       start,
    input  logic [9:0] NOTE,
    input  logic       note_valid,
    input  logic [9:0] store,
    output logic       note_req,
    output logic       busy,
    output logic       done,
    output logic [5:0] hits,
    output logic [2:0] grade,
    output logic [5:0] best
);

    localparam int CW = $clog2(NOTE_WIN + 1);
    localparam logic [CW-1:0] WIN_LAST  = CW'(NOTE_WIN - 1);
    localparam logic [CW-1:0] WIN_FULL  = CW'(NOTE_WIN);
    localparam logic [CW-1:0] HIT_THR   = CW'(HIT_MIN);
    localparam logic [5:0]    SONG_LAST = 6'(SONG_LEN - 1);
    localparam logic [9:0]    LEN10     = 10'(SONG_LEN);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_JUDGE  = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam logic [2:0] G_S = 3'd0;
    localparam logic [2:0] G_A = 3'd1;
    localparam logic [2:0] G_B = 3'd2;
    localparam logic [2:0] G_C = 3'd3;
    localparam logic [2:0] G_D = 3'd4;
    localparam logic [2:0] G_F = 3'd5;

    logic [2:0]    st, st_nxt;
    logic [1:0]    cur_user;
    logic [9:0]    exp_note;
    logic [CW-1:0] win_cnt, match_cnt;
    logic [5:0]    idx;
    logic [5:0]    best_a, best_b, best_c;
    logic [5:0]    cur_best;
    logic [2:0]    grade_calc;
    logic [9:0]    h10;
    logic          learn, accept;

    assign learn  = (state == LEARN_CODE);
    assign accept = (st == S_IDLE) && (st_nxt == S_REQ);

    always_comb begin
        st_nxt = st;
        case (st)
            S_IDLE:   if (start && learn && (WhichUser != 2'b00)) st_nxt = S_REQ;
            S_REQ:    st_nxt = S_WAIT;
            S_WAIT:   if (note_valid) st_nxt = S_JUDGE;
            S_JUDGE:  if (win_cnt == WIN_LAST) st_nxt = S_NEXT;
            S_NEXT:   st_nxt = (idx == SONG_LAST) ? S_FINISH : S_REQ;
            S_FINISH: st_nxt = S_IDLE;
            default:  st_nxt = S_IDLE;
        endcase
        // leaving learn mode abandons the session from any active state
        if (st != S_IDLE && !learn) st_nxt = S_IDLE;
    end

    // 10-bit products: 8*63 = 504 and 7*63 = 441 both fit
    always_comb begin
        h10 = {4'b0, hits};
        if (h10 == LEN10)                       grade_calc = G_S;
        else if ((h10 << 3) >= (LEN10 * 10'd7)) grade_calc = G_A;
        else if ((h10 << 2) >= (LEN10 * 10'd3)) grade_calc = G_B;
        else if ((h10 << 1) >= LEN10)           grade_calc = G_C;
        else if ((h10 << 2) >= LEN10)           grade_calc = G_D;
        else                                    grade_calc = G_F;
    end

    always_comb begin
        case (cur_user)
            2'b01:   cur_best = best_a;
            2'b10:   cur_best = best_b;
            2'b11:   cur_best = best_c;
            default: cur_best = 6'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= S_IDLE;
            cur_user  <= 2'b00;
            exp_note  <= 10'd0;
            win_cnt   <= '0;
            match_cnt <= '0;
            idx       <= 6'd0;
            hits      <= 6'd0;
            grade     <= G_F;
            best_a    <= 6'd0;
            best_b    <= 6'd0;
            best_c    <= 6'd0;
        end else begin
            st <= st_nxt;
            case (st)
                S_IDLE: if (accept) begin
                    cur_user <= WhichUser;
                    hits     <= 6'd0;
                    idx      <= 6'd0;
                end
                S_WAIT: if (note_valid) begin
                    exp_note  <= NOTE;
                    win_cnt   <= '0;
                    match_cnt <= '0;
                end
                S_JUDGE: begin
                    win_cnt <= win_cnt + 1'b1;
                    if (store == exp_note && match_cnt != WIN_FULL)
                        match_cnt <= match_cnt + 1'b1;
                end
                S_NEXT: if (learn) begin
                    if (match_cnt >= HIT_THR && hits != 6'd63) hits <= hits + 6'd1;
                    idx <= idx + 6'd1;
                end
                S_FINISH: if (learn) begin
                    grade <= grade_calc;
                    if (hits > cur_best) begin
                        case (cur_user)
                            2'b01:   best_a <= hits;
                            2'b10:   best_b <= hits;
                            2'b11:   best_c <= hits;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign note_req = (st == S_REQ) && learn;
    assign busy     = (st != S_IDLE);
    assign done     = (st == S_FINISH) && learn;

    always_comb begin
        case (WhichUser)
            2'b01:   best = best_a;
            2'b10:   best = best_b;
            2'b11:   best = best_c;
            default: best = 6'd0;
        endcase
    end

endmodule

// File: doc/learn_score_ctrl.md
LEARN_SCORE_CTRL -- requirements
Module: learn_score_ctrl

Interface
REQ-001 Parameter NOTE_WIN, default 50_000_000, note judging window length in clk cycles.
REQ-002 Parameter HIT_MIN, default 25_000_000, minimum matching cycles within a window for a hit.
REQ-003 Parameter SONG_LEN, default 32, notes per session (1..63).
REQ-004 Parameter LEARN_CODE, default 2'b10, value of state meaning learn mode.
REQ-005 clk  in  1  single system clock; all logic on posedge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 state  in  2  top-level mode; session runs only while state==LEARN_CODE.
REQ-008 WhichUser  in  2  user select: 01=A, 10=B, 11=C, 00=none.
REQ-009 start  in  1  one-cycle pulse requesting a session.
REQ-010 NOTE  in  10  expected one-hot key from song source, valid with note_valid.
REQ-011 note_valid  in  1  song source answers note_req; NOTE sampled this cycle.
REQ-012 store  in  10  live player key vector.
REQ-013 note_req  out  1  one-cycle pulse requesting next expected note.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle pulse when a session completes normally.
REQ-016 hits  out  6  hits in current/last session.
REQ-017 grade  out  3  letter for last completed session: 0=S,1=A,2=B,3=C,4=D,5=F.
REQ-018 best  out  6  stored best hits of user currently on WhichUser (0 for 00).

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, JUDGE, NEXT, FINISH.
REQ-020 IDLE->REQ when start=1, state==LEARN_CODE, WhichUser!=00; user latched into cur_user, hits and note index cleared; otherwise start ignored.
REQ-021 REQ: note_req=1 for exactly one cycle, then WAIT.
REQ-022 WAIT: on note_valid=1 capture NOTE into exp_note, clear win_cnt and match_cnt, go JUDGE; no timeout.
REQ-023 JUDGE: each cycle win_cnt+1; match_cnt+1 when store==exp_note (exact 10-bit equality); match_cnt saturates at NOTE_WIN.
REQ-024 JUDGE exits to NEXT on the cycle win_cnt reaches NOTE_WIN-1 (window exactly NOTE_WIN cycles).
REQ-025 NEXT: if match_cnt>=HIT_MIN, hits+1 (saturating at 63); note index+1; to FINISH if index==SONG_LEN-1 before increment, else REQ.
REQ-026 FINISH (one cycle): compute grade, update best of cur_user if hits>best, pulse done, return IDLE.
REQ-027 Grade from hits h vs L=SONG_LEN: S if h==L; A if 8h>=7L; B if 4h>=3L; C if 2h>=L; D if 4h>=L; else F; products formed at >=9 bits without overflow.
REQ-028 Abort: if state!=LEARN_CODE in any non-IDLE state, next state IDLE; no done, grade and best unchanged, hits retains partial count.
REQ-029 WhichUser changes mid-session SHALL not affect cur_user; best output always tracks live WhichUser.
REQ-030 start while busy SHALL be ignored.
REQ-031 note_valid outside WAIT SHALL be ignored.
REQ-032 Three best registers (A,B,C) SHALL be independent; only cur_user's may change, only in FINISH.

Reset
REQ-033 rst=0 SHALL immediately force IDLE, note_req=0, busy=0, done=0, hits=0, grade=5 (F), all best registers=0, counters cleared, regardless of state, including mid-JUDGE.
REQ-034 After rst deasserts, first start is accepted no earlier than the next posedge.

Verification (NOTE_WIN=8, HIT_MIN=4, SONG_LEN=4)
REQ-035 User A, store==NOTE throughout all 4 windows -> 4 note_req pulses, hits=4, grade=0 (S), done pulse, best(A)=4.
REQ-036 User B, match 3 cycles per window in every window -> hits=0, grade=5 (F), best(B) stays 0; then start with full match -> best(B)=4, best(A) unchanged.
REQ-037 User C, hits on notes 1,2 only -> hits=2, 2h>=L so grade=3 (C); rerun with 1 hit -> grade=4 (D), best(C) remains 2.
REQ-038 state leaves LEARN_CODE during note 3 JUDGE -> IDLE next cycle, no done, grade/best unchanged; start with WhichUser=00 -> stays IDLE.
REQ-039 rst asserted mid-JUDGE of user A after prior best 4 -> busy=0, hits=0, grade=5, best(A)=0 asynchronously.
